// File: rtl/hit_judge.sv
// hit_judge: debounces the red/blue play buttons, judges presses against the judge-position note and keeps score.
// A raw rise stable before edge k registers delete at edge k+2+DEBOUNCE_CYCLES; no backpressure, delete is a fire-and-forget pulse.
module hit_judge #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [2:0]  PERF_LO         = 3'd2,
  parameter logic [2:0]  PERF_HI         = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        note_R_judge,
  input  logic        note_B_judge,
  input  logic [2:0]  offset,
  input  logic        finish,
  output logic        delete,
  output logic [15:0] score,
  output logic [7:0]  perfect_cnt,
  output logic [7:0]  good_cnt,
  output logic [7:0]  miss_cnt
);

  typedef enum logic {
    PLAY = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       db;
  logic [1:0]       db_d;
  logic [1:0]       press;
  logic [1:0][15:0] cnt;

  logic [2:0]  prev_offset;
  logic        seen;
  logic        consumed;
  logic        boundary;
  logic        slot_open;
  logic        hit;
  logic        perfect;
  logic        miss;
  logic [16:0] score_sum;
  logic [15:0] score_next;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Bit 0 is red, bit 1 is blue throughout the button path.
  assign raw   = {blue_button, red_button};
  assign press = db & ~db_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      s2   <= '0;
      db   <= '0;
      db_d <= '0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_d <= db;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEBOUNCE_CYCLES - 16'd1) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  // At a boundary the press belongs to the new slot, so the old consumed flag must not block it.
  assign boundary  = (prev_offset == 3'd6) && (offset == 3'd0);
  assign slot_open = boundary | ~consumed;
  assign hit       = (state == PLAY) && !finish && slot_open &&
                     ((press[0] & note_R_judge) | (press[1] & note_B_judge));
  assign perfect   = (offset >= PERF_LO) && (offset <= PERF_HI);
  assign miss      = (state == PLAY) && boundary && seen && !consumed;

  assign score_sum  = {1'b0, score} + (perfect ? 17'd3 : 17'd1);
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= PLAY;
      prev_offset <= '0;
      seen        <= 1'b0;
      consumed    <= 1'b0;
      delete      <= 1'b0;
      score       <= '0;
      perfect_cnt <= '0;
      good_cnt    <= '0;
      miss_cnt    <= '0;
    end else begin
      prev_offset <= offset;
      delete      <= hit;
      seen        <= (seen & ~boundary) | note_R_judge | note_B_judge;
      consumed    <= (consumed & ~boundary) | hit;
      case (state)
        PLAY: begin
          if (finish) state <= DONE;
          if (hit) begin
            score <= score_next;
            if (perfect) perfect_cnt <= sat_inc(perfect_cnt);
            else         good_cnt    <= sat_inc(good_cnt);
          end
          if (miss) miss_cnt <= sat_inc(miss_cnt);
        end
        DONE: begin
          if (!finish) begin
            state       <= PLAY;
            score       <= '0;
            perfect_cnt <= '0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed scenarios with literal expectations plus a randomized run against a behavioural model.
module tb_hit_judge;

  localparam int         D       = 4;
  localparam logic [2:0] PERF_LO = 3'd2;
  localparam logic [2:0] PERF_HI = 3'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        red_button = 1'b0;
  logic        blue_button = 1'b0;
  logic        note_R_judge = 1'b0;
  logic        note_B_judge = 1'b0;
  logic [2:0]  offset = 3'd0;
  logic        finish = 1'b0;
  logic        delete;
  logic [15:0] score;
  logic [7:0]  perfect_cnt;
  logic [7:0]  good_cnt;
  logic [7:0]  miss_cnt;

  int checks = 0;
  int errors = 0;
  int n_del = 0;

  hit_judge #(.DEBOUNCE_CYCLES(16'd4), .PERF_LO(PERF_LO), .PERF_HI(PERF_HI)) dut (
    .clk(clk), .rst(rst), .red_button(red_button), .blue_button(blue_button),
    .note_R_judge(note_R_judge), .note_B_judge(note_B_judge), .offset(offset),
    .finish(finish), .delete(delete), .score(score), .perfect_cnt(perfect_cnt),
    .good_cnt(good_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Behavioural model: a button level flips once the last D synchronized samples all disagree with it;
  // the game state simply follows the registered finish level.
  int   m_score, m_perf, m_good, m_miss;
  logic m_del, m_seen, m_cons, m_done;
  logic [2:0] m_prev;
  logic [1:0] m_db, m_dbd;
  logic hist [2][D+2];

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_step();
    logic pr, pb, bnd, hit, miss, flip;
    logic [1:0] rawv;
    if (rst) begin
      m_score = 0; m_perf = 0; m_good = 0; m_miss = 0;
      m_del = 0; m_seen = 0; m_cons = 0; m_done = 0; m_prev = 0;
      m_db = 0; m_dbd = 0;
      for (int b = 0; b < 2; b++)
        for (int k = 0; k < D + 2; k++) hist[b][k] = 1'b0;
    end else begin
      pr   = m_db[0] & ~m_dbd[0];
      pb   = m_db[1] & ~m_dbd[1];
      bnd  = (m_prev == 3'd6) && (offset == 3'd0);
      hit  = !m_done && !finish && (bnd || !m_cons) &&
             ((pr && note_R_judge) || (pb && note_B_judge));
      miss = bnd && !m_done && m_seen && !m_cons;
      if (m_done && !finish) begin
        m_score = 0; m_perf = 0; m_good = 0; m_miss = 0;
      end else if (!m_done) begin
        if (hit) begin
          if (offset >= PERF_LO && offset <= PERF_HI) begin
            m_score = sat(m_score + 3, 65535);
            m_perf  = sat(m_perf + 1, 255);
          end else begin
            m_score = sat(m_score + 1, 65535);
            m_good  = sat(m_good + 1, 255);
          end
        end
        if (miss) m_miss = sat(m_miss + 1, 255);
      end
      m_del  = hit;
      m_seen = (!bnd && m_seen) || note_R_judge || note_B_judge;
      m_cons = (!bnd && m_cons) || hit;
      m_done = finish;
      m_prev = offset;
      m_dbd  = m_db;
      rawv   = {blue_button, red_button};
      for (int b = 0; b < 2; b++) begin
        for (int k = D + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
        hist[b][0] = rawv[b];
        flip = 1'b1;
        for (int k = 2; k <= D + 1; k++)
          if (hist[b][k] == m_db[b]) flip = 1'b0;
        if (flip) m_db[b] = ~m_db[b];
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #2;
    chk("delete", int'(delete), int'(m_del));
    chk("score", int'(score), m_score);
    chk("perfect_cnt", int'(perfect_cnt), m_perf);
    chk("good_cnt", int'(good_cnt), m_good);
    chk("miss_cnt", int'(miss_cnt), m_miss);
    if (delete) n_del++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int d0;
  int hold_r, hold_b;

  initial begin
    // Reset values, then reset in the middle of a debounce count.
    cyc(3);
    chk("rst_delete", int'(delete), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_counts", int'({perfect_cnt, good_cnt, miss_cnt}), 0);
    rst = 1'b0;
    offset = 3'd3; note_R_judge = 1'b1;
    @(negedge clk);
    red_button = 1'b1;
    cyc(3);
    rst = 1'b1;
    d0 = n_del;
    cyc(6);
    red_button = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(12);
    chk("rst_abort_no_delete", n_del - d0, 0);
    chk("rst_abort_score", int'(score), 0);

    // Perfect hit: delete only in the cycle after edge 6.
    do_reset();
    @(negedge clk);
    red_button = 1'b1;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk);
      #2;
      chk($sformatf("perf_delete_e%0d", e), int'(delete), (e == 6) ? 1 : 0);
    end
    chk("perf_score", int'(score), 3);
    chk("perf_cnt", int'(perfect_cnt), 1);
    @(negedge clk);
    red_button = 1'b0;
    cyc(10);

    // Good hit at offset 6, then a duplicate press in the same slot.
    note_R_judge = 1'b0; note_B_judge = 1'b1; offset = 3'd6;
    do_reset();
    d0 = n_del;
    blue_button = 1'b1;
    cyc(10);
    chk("good_delete", n_del - d0, 1);
    chk("good_score", int'(score), 1);
    chk("good_cnt", int'(good_cnt), 1);
    blue_button = 1'b0;
    cyc(10);
    d0 = n_del;
    blue_button = 1'b1;
    cyc(10);
    chk("dup_no_delete", n_del - d0, 0);
    chk("dup_score", int'(score), 1);
    blue_button = 1'b0;
    cyc(10);

    // Missed note across a slot boundary, then an empty slot.
    note_B_judge = 1'b0;
    do_reset();
    for (int o = 1; o <= 6; o++) begin
      @(negedge clk);
      offset = 3'(o); note_R_judge = 1'b1;
    end
    @(negedge clk);
    offset = 3'd0; note_R_judge = 1'b0;
    @(negedge clk);
    chk("miss_one", int'(miss_cnt), 1);
    for (int o = 1; o <= 6; o++) begin
      @(negedge clk);
      offset = 3'(o);
    end
    @(negedge clk);
    offset = 3'd0;
    @(negedge clk);
    chk("miss_empty_slot", int'(miss_cnt), 1);

    // Bounce rejection, then a short glitch.
    offset = 3'd3; note_R_judge = 1'b1;
    do_reset();
    d0 = n_del;
    for (int t = 0; t < 10; t++) begin
      red_button = ~red_button;
      cyc(2);
    end
    red_button = 1'b1;
    cyc(12);
    chk("bounce_one_delete", n_del - d0, 1);
    red_button = 1'b0;
    cyc(10);
    do_reset();
    d0 = n_del;
    red_button = 1'b1;
    cyc(3);
    red_button = 1'b0;
    cyc(12);
    chk("glitch_no_delete", n_del - d0, 0);

    // Saturation from a preloaded state, then finish handling.
    do_reset();
    @(negedge clk);
    force dut.score = 16'hFFFE;
    force dut.perfect_cnt = 8'hFF;
    m_score = 16'hFFFE;
    m_perf  = 255;
    #1;
    release dut.score;
    release dut.perfect_cnt;
    d0 = n_del;
    red_button = 1'b1;
    cyc(10);
    chk("sat_delete", n_del - d0, 1);
    chk("sat_score", int'(score), 16'hFFFF);
    chk("sat_perfect", int'(perfect_cnt), 255);
    red_button = 1'b0;
    cyc(10);
    finish = 1'b1;
    cyc(2);
    offset = 3'd6;
    cyc(1);
    offset = 3'd0;
    cyc(1);
    d0 = n_del;
    red_button = 1'b1;
    cyc(10);
    chk("done_no_delete", n_del - d0, 0);
    chk("done_score_hold", int'(score), 16'hFFFF);
    chk("done_miss_hold", int'(miss_cnt), 0);
    red_button = 1'b0;
    cyc(10);
    finish = 1'b0;
    @(negedge clk);
    chk("restart_score", int'(score), 0);
    chk("restart_counts", int'({perfect_cnt, good_cnt, miss_cnt}), 0);

    // Randomized run against the model.
    offset = 3'd0; note_R_judge = 1'b0; note_B_judge = 1'b0;
    do_reset();
    hold_r = 0; hold_b = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) rst = 1'b1;
      if (c == 1502) rst = 1'b0;
      if ($urandom_range(3, 0) != 0) begin
        offset = (offset == 3'd6) ? 3'd0 : offset + 3'd1;
        if (offset == 3'd0) begin
          note_R_judge = 1'($urandom_range(1, 0));
          note_B_judge = ($urandom_range(2, 0) == 0);
        end
      end
      if (hold_r == 0) begin
        red_button = ~red_button;
        hold_r = $urandom_range(12, 1);
      end else hold_r--;
      if (hold_b == 0) begin
        blue_button = ~blue_button;
        hold_b = $urandom_range(12, 1);
      end else hold_b--;
      if (finish) begin
        if ($urandom_range(15, 0) == 0) finish = 1'b0;
      end else if ($urandom_range(199, 0) == 0) begin
        finish = 1'b1;
      end
    end
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
